// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register arbiter: FSM states, index-width
// helper and fixed-width one-hot/index conversions.
package shared_reg_pkg;

    typedef enum logic {IDLE, GRANT} state_t;

    localparam int unsigned MAX_N     = 16;
    localparam int unsigned MAX_IDX_W = 4;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_N-1:0] idx_to_onehot(input logic [MAX_IDX_W-1:0] idx);
        logic [MAX_N-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (oh[i]) idx = idx | MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational circular priority picker: first set req bit at or after start,
// wrapping from N-1 back to 0.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] winner
);

    logic [IW:0] cand;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // start < N and k < N, so one conditional subtract is a full modulo
            cand = {1'b0, start} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
            if (!found && req[cand[IW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared W-bit register with
// registered q/qbar; grants rotate on request drop or after MAX_HOLD writes.
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned W        = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    input  logic [N*W-1:0]         wdata,
    output logic [N-1:0]           gnt,
    output logic [W-1:0]           q,
    output logic [W-1:0]           qbar,
    output logic [idx_w(N)-1:0]    owner,
    output logic                   valid
);

    localparam int unsigned IW        = idx_w(N);
    localparam int unsigned HW        = idx_w(MAX_HOLD);
    localparam logic [IW-1:0] LAST    = IW'(N-1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD-1);

    state_t        state, state_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [N-1:0]  gnt_n, win_oh;
    logic [IW-1:0] cur, cur_next, start, winner;
    logic          we, rel, found;
    logic [W-1:0]  wsel;

    // The grantee index is derived from the registered one-hot grant.
    assign cur      = IW'(onehot_to_idx(MAX_N'(gnt)));
    assign cur_next = (cur == LAST) ? '0 : cur + 1'b1;
    assign we       = |(gnt & req);
    assign rel      = (state == GRANT) && (!we || hold_cnt == HOLD_LAST);
    assign start    = (state == GRANT) ? cur_next : ptr;
    assign win_oh   = N'(idx_to_onehot(MAX_IDX_W'(winner)));

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .start  (start),
        .found  (found),
        .winner (winner)
    );

    always_comb begin
        wsel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt[i]) wsel = wsel | wdata[i*W +: W];
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        gnt_n   = gnt;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = GRANT;
                    gnt_n   = win_oh;
                    hold_n  = '0;
                end
            end
            GRANT: begin
                if (rel) begin
                    // Re-arbitrate in the same edge, current grantee searched last
                    ptr_n  = cur_next;
                    hold_n = '0;
                    if (found) begin
                        gnt_n = win_oh;
                    end else begin
                        gnt_n   = '0;
                        state_n = IDLE;
                    end
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            gnt      <= gnt_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= '0;
            qbar  <= '1;
            owner <= '0;
            valid <= 1'b0;
        end else if (we) begin
            q     <= wsel;
            qbar  <= ~wsel;
            owner <= cur;
            valid <= 1'b1;
        end
    end

endmodule
